acc_requant_packer: RTL and testbench

- Drains signed ACCUM_WIDTH accumulator results from the MAC datapath, one per beat, and requantizes each back to DATA_WIDTH.
- Requantization is bias add, arithmetic right shift with rounding, optional ReLU, then saturation.
- Packs VEC requantized lanes into one VEC*DATA_WIDTH vector, in the same lane layout the MAC consumes, and hands it to activation writeback over a valid/ready stream.
- It is the return path of the MAC: wide scalars in, packed narrow vectors out.

---
 rtl/acc_requant_pkg.sv | 20 ++
 rtl/requant_lane.sv | 48 ++++
 rtl/acc_requant_packer.sv | 134 +++++++++++++
 tb/tb_acc_requant_packer.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_requant_pkg.sv
// rtl/acc_requant_pkg.sv - shared widths, lane/accumulator types and clamp limits for the requant packer
package acc_requant_pkg;

   localparam int DATA_WIDTH  = 16;
   localparam int ACCUM_WIDTH = 48;
   localparam int VEC         = 16;
   localparam int SHIFT_WIDTH = 6;
   localparam int LANE_IDX_W  = $clog2(VEC);

   typedef logic signed [DATA_WIDTH-1:0]  lane_t;
   typedef logic signed [ACCUM_WIDTH-1:0] acc_t;
   typedef logic signed [ACCUM_WIDTH:0]   sum_t;

   localparam lane_t LANE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam lane_t LANE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // Largest meaningful shift; anything above is clamped to this.
   localparam logic [SHIFT_WIDTH-1:0] SHIFT_MAX = SHIFT_WIDTH'(ACCUM_WIDTH - 1);

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - combinational shift clamp, round-half-up, ReLU and saturation of one lane
// Ports:
//   sum   : biased accumulator, ACCUM_WIDTH+1 bits signed
//   shift : right-shift amount (clamped to ACCUM_WIDTH-1)
//   relu  : force negative results to zero
//   lane  : requantized, saturated lane value
//   sat   : the saturation clamp was active
module requant_lane
   import acc_requant_pkg::*;
(
   input  sum_t                   sum,
   input  logic [SHIFT_WIDTH-1:0] shift,
   input  logic                   relu,
   output lane_t                  lane,
   output logic                   sat
);

   // One extra bit over sum_t so adding the rounding half never overflows.
   localparam int RW = ACCUM_WIDTH + 2;

   logic [SHIFT_WIDTH-1:0] sh;
   logic signed [RW-1:0]   half;
   logic signed [RW-1:0]   rounded;
   logic signed [RW-1:0]   r;
   logic                   in_range;

   always_comb begin
      sh = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
      half = '0;
      if (sh != '0) begin
         half[sh - 1'b1] = 1'b1;
      end
      rounded = {sum[ACCUM_WIDTH], sum} + half;
      r = rounded >>> sh;
      if (relu && r[RW-1]) begin
         r = '0;
      end
      // Fits in a lane when every bit above the lane MSB equals the sign.
      in_range = (&r[RW-1:DATA_WIDTH-1]) || !(|r[RW-1:DATA_WIDTH-1]);
      sat = !in_range;
      if (in_range) begin
         lane = r[DATA_WIDTH-1:0];
      end else begin
         lane = r[RW-1] ? LANE_MIN : LANE_MAX;
      end
   end

endmodule

// File: rtl/acc_requant_packer.sv
// rtl/acc_requant_packer.sv - requantizes accumulator beats and packs VEC lanes into output vectors
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid/in_ready : accumulator beat handshake
//   in_acc, in_bias   : signed accumulator and bias
//   in_shift, in_relu : per-beat requant controls
//   in_last           : last beat of a row, flushes a partial vector
//   out_valid/out_ready, out_data, out_mask, out_last : packed vector stream
//   sat_flag, sat_clr : sticky saturation indicator and its clear
module acc_requant_packer
   import acc_requant_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  acc_t                       in_acc,
   input  acc_t                       in_bias,
   input  logic [SHIFT_WIDTH-1:0]     in_shift,
   input  logic                       in_relu,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [VEC*DATA_WIDTH-1:0]  out_data,
   output logic [VEC-1:0]             out_mask,
   output logic                       out_last,
   output logic                       sat_flag,
   input  logic                       sat_clr
);

   logic stall;

   logic                   s1_valid;
   sum_t                   s1_sum;
   logic [SHIFT_WIDTH-1:0] s1_shift;
   logic                   s1_relu;
   logic                   s1_last;

   lane_t rq_lane;
   logic  rq_sat;

   logic  s2_valid;
   lane_t s2_lane;
   logic  s2_sat;
   logic  s2_last;

   logic [LANE_IDX_W-1:0]     lane_cnt;
   logic [VEC*DATA_WIDTH-1:0] pack_buf;
   logic [VEC*DATA_WIDTH-1:0] buf_next;
   logic [VEC-1:0]            mask_next;
   logic                      complete;
   logic                      p_write;

   // A held output vector freezes the whole pipeline.
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   requant_lane u_requant (
      .sum   (s1_sum),
      .shift (s1_shift),
      .relu  (s1_relu),
      .lane  (rq_lane),
      .sat   (rq_sat)
   );

   always_comb begin
      p_write  = s2_valid & ~stall;
      complete = s2_last | (lane_cnt == LANE_IDX_W'(VEC - 1));
      buf_next = pack_buf;
      buf_next[lane_cnt*DATA_WIDTH +: DATA_WIDTH] = s2_lane;
      mask_next = '0;
      for (int i = 0; i < VEC; i++) begin
         mask_next[i] = (i <= int'(lane_cnt));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid  <= 1'b0;
         s1_sum    <= '0;
         s1_shift  <= '0;
         s1_relu   <= 1'b0;
         s1_last   <= 1'b0;
         s2_valid  <= 1'b0;
         s2_lane   <= '0;
         s2_sat    <= 1'b0;
         s2_last   <= 1'b0;
         lane_cnt  <= '0;
         pack_buf  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_mask  <= '0;
         out_last  <= 1'b0;
         sat_flag  <= 1'b0;
      end else begin
         if (!stall) begin
            s1_valid <= in_valid;
            s1_sum   <= {in_acc[ACCUM_WIDTH-1], in_acc} + {in_bias[ACCUM_WIDTH-1], in_bias};
            s1_shift <= in_shift;
            s1_relu  <= in_relu;
            s1_last  <= in_last;

            s2_valid <= s1_valid;
            s2_lane  <= rq_lane;
            s2_sat   <= rq_sat;
            s2_last  <= s1_last;

            // Not stalled means the current vector (if any) is consumed now,
            // so out_valid simply follows whether a new vector completes.
            out_valid <= s2_valid & complete;
            if (s2_valid) begin
               if (complete) begin
                  out_data <= buf_next;
                  out_mask <= mask_next;
                  out_last <= s2_last;
                  lane_cnt <= '0;
                  pack_buf <= '0;
               end else begin
                  pack_buf <= buf_next;
                  lane_cnt <= lane_cnt + 1'b1;
               end
            end
         end

         // Set has priority over clear.
         if (p_write && s2_sat) begin
            sat_flag <= 1'b1;
         end else if (sat_clr) begin
            sat_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_acc_requant_packer.sv
// tb/tb_acc_requant_packer.sv - self-checking bench for acc_requant_packer
module tb_acc_requant_packer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [47:0]  in_acc = '0;
   logic [47:0]  in_bias = '0;
   logic [5:0]   in_shift = '0;
   logic         in_relu = 1'b0;
   logic         in_last = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [255:0] out_data;
   logic [15:0]  out_mask;
   logic         out_last;
   logic         sat_flag;
   logic         sat_clr = 1'b0;

   acc_requant_packer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_acc    (in_acc),
      .in_bias   (in_bias),
      .in_shift  (in_shift),
      .in_relu   (in_relu),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_mask  (out_mask),
      .out_last  (out_last),
      .sat_flag  (sat_flag),
      .sat_clr   (sat_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [255:0] data;
      logic [15:0]  mask;
      logic         last;
   } vec_t;

   vec_t         exp_q[$];
   vec_t         got_q[$];
   logic [255:0] m_buf = '0;
   int           m_k = 0;
   int           n_cmp = 0;
   int           n_err = 0;

   // Records every vector that is handed over on the following rising edge.
   always begin : collect
      vec_t v;
      @(negedge clk);
      #1;
      if (rst && out_valid && out_ready) begin
         v.data = out_data;
         v.mask = out_mask;
         v.last = out_last;
         got_q.push_back(v);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [15:0] ref_lane(longint acc, longint bias, int shift, bit relu,
                                           output bit sat);
      longint s;
      longint r;
      int     sh;
      s  = acc + bias;
      sh = (shift > 47) ? 47 : shift;
      if (sh == 0) r = s;
      else         r = (s + (longint'(1) << (sh - 1))) >>> sh;
      if (relu && r < 0) r = 0;
      sat = 1'b0;
      if (r > 32767) begin
         r = 32767;
         sat = 1'b1;
      end else if (r < -32768) begin
         r = -32768;
         sat = 1'b1;
      end
      return r[15:0];
   endfunction

   task automatic model_reset();
      m_buf = '0;
      m_k = 0;
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic model_beat(longint acc, longint bias, int shift, bit relu, bit last);
      bit          s;
      logic [15:0] l;
      vec_t        v;
      l = ref_lane(acc, bias, shift, relu, s);
      m_buf[m_k*16 +: 16] = l;
      if (last || m_k == 15) begin
         v.data = m_buf;
         v.mask = 16'((32'd1 << (m_k + 1)) - 1);
         v.last = last;
         exp_q.push_back(v);
         m_buf = '0;
         m_k = 0;
      end else begin
         m_k++;
      end
   endtask

   // Called just after a falling edge; returns just after the falling edge
   // that follows the accepting rising edge.
   task automatic send_beat(longint acc, longint bias, int shift, bit relu, bit last);
      int guard = 0;
      in_valid = 1'b1;
      in_acc   = acc[47:0];
      in_bias  = bias[47:0];
      in_shift = shift[5:0];
      in_relu  = relu;
      in_last  = last;
      #1;
      while (!in_ready && guard < 300) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      end else begin
         @(posedge clk);
         model_beat(acc, bias, shift, relu, last);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      out_ready = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++;
      if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      n_cmp++;
      if (out_mask !== 16'h0) begin n_err++; $display("FAIL reset_out_mask: got %h want 0", out_mask); end
      n_cmp++;
      if (out_last !== 1'b0 || sat_flag !== 1'b0) begin
         n_err++; $display("FAIL reset_last_sat: got %b/%b want 0/0", out_last, sat_flag);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_rounding();
      longint      accs[3];
      logic [15:0] want[3];
      vec_t        g;
      vec_t        e;
      accs = '{64'sh12345, 64'sd24, -64'sd24};
      want = '{16'h1234, 16'h0002, 16'hFFFF};
      for (int i = 0; i < 3; i++) send_beat(accs[i], 0, 4, 1'b0, 1'b1);
      wait_drain();
      n_cmp++;
      if (got_q.size() != 3 || exp_q.size() != 3) begin
         n_err++;
         $display("FAIL round_count: got %0d vectors want 3 (model %0d)", got_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g.data[15:0] !== want[i] || g.mask !== 16'h0001 || g.last !== 1'b1) begin
               n_err++;
               $display("FAIL round_lane%0d: got %h mask %h last %b want %h mask 0001 last 1",
                        i, g.data[15:0], g.mask, g.last, want[i]);
            end
            n_cmp++;
            if (g.data !== e.data) begin
               n_err++; $display("FAIL round_model%0d: got %h want %h", i, g.data, e.data);
            end
         end
      end
      model_reset();
   endtask

   task automatic test_saturation();
      longint      accs[3];
      bit          relus[3];
      logic [15:0] want[3];
      bit          want_sat[3];
      vec_t        g;
      accs     = '{64'sd40000, -64'sd40000, -64'sd40000};
      relus    = '{1'b0, 1'b0, 1'b1};
      want     = '{16'h7FFF, 16'h8000, 16'h0000};
      want_sat = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         sat_clr = 1'b1;
         @(negedge clk);
         sat_clr = 1'b0;
         send_beat(accs[i], 0, 0, relus[i], 1'b1);
         wait_drain();
         #1;
         n_cmp++;
         if (sat_flag !== want_sat[i]) begin
            n_err++; $display("FAIL sat_flag%0d: got %b want %b", i, sat_flag, want_sat[i]);
         end
         n_cmp++;
         if (got_q.size() != 1) begin
            n_err++; $display("FAIL sat_count%0d: got %0d vectors want 1", i, got_q.size());
         end else begin
            g = got_q.pop_front();
            n_cmp++;
            if (g.data[15:0] !== want[i]) begin
               n_err++; $display("FAIL sat_lane%0d: got %h want %h", i, g.data[15:0], want[i]);
            end
         end
         model_reset();
      end
      // Clear held high across the saturating write: the set must win on that edge.
      sat_clr = 1'b1;
      @(negedge clk);
      send_beat(64'sd40000, 0, 0, 1'b0, 1'b1);
      #1;
      n_cmp++;
      if (sat_flag !== 1'b0) begin n_err++; $display("FAIL satclr_before: got %b want 0", sat_flag); end
      @(negedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (sat_flag !== 1'b1) begin n_err++; $display("FAIL satclr_setwins: got %b want 1", sat_flag); end
      @(negedge clk);
      #1;
      n_cmp++;
      if (sat_flag !== 1'b0) begin n_err++; $display("FAIL satclr_after: got %b want 0", sat_flag); end
      sat_clr = 1'b0;
      wait_drain();
      model_reset();
   endtask

   task automatic test_full_vector();
      logic [255:0] want = '0;
      vec_t         g;
      vec_t         e;
      for (int i = 0; i < 16; i++) begin
         want[i*16 +: 16] = 16'(i);
         send_beat(i * 16, 0, 4, 1'b0, 1'b0);
      end
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_lat_e0: out_valid %b want 0", out_valid); end
      @(negedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_lat_e1: out_valid %b want 0", out_valid); end
      @(negedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_lat_e2: out_valid %b want 1", out_valid); end
      n_cmp++;
      if (out_data !== want || out_mask !== 16'hFFFF || out_last !== 1'b0) begin
         n_err++;
         $display("FAIL full_vec: data %h mask %h last %b want %h mask ffff last 0",
                  out_data, out_mask, out_last, want);
      end
      wait_drain();
      n_cmp++;
      if (got_q.size() != 1 || exp_q.size() != 1) begin
         n_err++; $display("FAIL full_count: got %0d vectors want 1", got_q.size());
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (g.data !== e.data || g.mask !== e.mask || g.last !== e.last) begin
            n_err++; $display("FAIL full_model: got %h/%h want %h/%h", g.data, g.mask, e.data, e.mask);
         end
      end
      model_reset();
   endtask

   task automatic test_partial_flush();
      vec_t g0;
      vec_t g1;
      vec_t e0;
      for (int i = 0; i < 5; i++) begin
         send_beat(longint'($urandom_range(1, 30000)), 0, 0, 1'b0, i == 4);
      end
      send_beat(7, 0, 0, 1'b0, 1'b1);
      wait_drain();
      n_cmp++;
      if (got_q.size() != 2 || exp_q.size() != 2) begin
         n_err++; $display("FAIL flush_count: got %0d vectors want 2", got_q.size());
      end else begin
         g0 = got_q.pop_front();
         g1 = got_q.pop_front();
         e0 = exp_q.pop_front();
         n_cmp++;
         if (g0.mask !== 16'h001F || g0.last !== 1'b1 || g0.data[255:80] !== '0) begin
            n_err++;
            $display("FAIL flush_vec: mask %h last %b upper %h want mask 001f last 1 upper 0",
                     g0.mask, g0.last, g0.data[255:80]);
         end
         n_cmp++;
         if (g0.data !== e0.data) begin
            n_err++; $display("FAIL flush_model: got %h want %h", g0.data, e0.data);
         end
         n_cmp++;
         if (g1.mask !== 16'h0001 || g1.data !== 256'd7) begin
            n_err++; $display("FAIL flush_next_lane0: mask %h data %h want 0001 / 7", g1.mask, g1.data);
         end
      end
      model_reset();
   endtask

   task automatic test_backpressure();
      vec_t g;
      vec_t e;
      @(negedge clk);
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               send_beat(longint'($urandom_range(1, 30000)), 0, 0, 1'b0, i == 19);
            end
         end
         begin
            logic [255:0] held;
            int           guard = 0;
            @(negedge clk);
            #1;
            while (!out_valid && guard < 100) begin
               @(negedge clk);
               #1;
               guard++;
            end
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
               n_err++;
               $display("FAIL bp_stall: out_valid %b in_ready %b want 1/0", out_valid, in_ready);
            end
            held = out_data;
            repeat (10) begin
               @(negedge clk);
               #1;
               n_cmp++;
               if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                  n_err++;
                  $display("FAIL bp_hold: data %h valid %b ready %b want %h 1 0",
                           out_data, out_valid, in_ready, held);
               end
            end
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      wait_drain();
      n_cmp++;
      if (got_q.size() != 2 || exp_q.size() != 2) begin
         n_err++; $display("FAIL bp_count: got %0d vectors want 2", got_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g.data !== e.data || g.mask !== e.mask || g.last !== e.last) begin
               n_err++;
               $display("FAIL bp_vec%0d: got %h/%h/%b want %h/%h/%b",
                        i, g.data, g.mask, g.last, e.data, e.mask, e.last);
            end
         end
      end
      model_reset();
   endtask

   task automatic test_reset_mid_vector();
      vec_t g;
      vec_t e;
      for (int i = 0; i < 7; i++) send_beat(longint'($urandom_range(1, 30000)), 0, 0, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_mask !== 16'h0 || out_last !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_outputs: valid %b data %h mask %h last %b want all 0",
                  out_valid, out_data, out_mask, out_last);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 16; i++) send_beat(longint'($urandom_range(1, 30000)), 0, 0, 1'b0, 1'b0);
      wait_drain();
      n_cmp++;
      if (got_q.size() != 1 || exp_q.size() != 1) begin
         n_err++; $display("FAIL rstmid_count: got %0d vectors want 1", got_q.size());
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (g.data !== e.data || g.mask !== 16'hFFFF) begin
            n_err++; $display("FAIL rstmid_vec: got %h/%h want %h/ffff", g.data, g.mask, e.data);
         end
      end
      model_reset();
   endtask

   task automatic test_random();
      bit   done = 1'b0;
      vec_t g;
      vec_t e;
      int   n;
      fork
         begin
            for (int i = 0; i < 80; i++) begin
               longint acc;
               longint bias;
               case ($urandom_range(0, 2))
                  0: acc = longint'($urandom_range(0, 200000)) - 100000;
                  1: begin acc = {$urandom, $urandom}; acc = acc >>> 16; end
                  default: acc = longint'($urandom_range(0, 1 << 20)) - (1 << 19);
               endcase
               if ($urandom_range(0, 3) == 0) begin
                  bias = {$urandom, $urandom};
                  bias = bias >>> 16;
               end else begin
                  bias = longint'($urandom_range(0, 2000)) - 1000;
               end
               send_beat(acc, bias, int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                         (i == 79) || ($urandom_range(0, 7) == 0));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      wait_drain();
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_err++; $display("FAIL rand_count: got %0d vectors want %0d", got_q.size(), exp_q.size());
      end
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (g.data !== e.data || g.mask !== e.mask || g.last !== e.last) begin
            n_err++;
            $display("FAIL rand_vec%0d: got %h/%h/%b want %h/%h/%b",
                     i, g.data, g.mask, g.last, e.data, e.mask, e.last);
         end
      end
      model_reset();
   endtask

   initial begin
      test_reset();
      test_rounding();
      test_saturation();
      test_full_vector();
      test_partial_flush();
      test_backpressure();
      test_reset_mid_vector();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
